// File: rtl/armv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : armv8_pkg
//  Description : Shared types and constants for the ARMv8 memory/PC-update
//                stage: access-sequencer state encoding, PC increment and
//                default reset PC.
//  Revision    : 1.0  initial release
// ============================================================================
package armv8_pkg;

  // Access sequencer: one IDLE cycle to latch, two word cycles, one
  // release cycle in which the PC is allowed to move.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic [63:0] PC_INCR          = 64'd4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage
`default_nettype wire

// File: rtl/mem_stage_dmem32.sv
`default_nettype none
// ============================================================================
//  Module      : dmem32
//  Description : 2**WORD_AW x 32-bit data SRAM. Synchronous write,
//                combinational read. Contents are not reset.
//  Ports       : clk            clock
//                we/waddr/wdata write port (rising edge)
//                raddr/rdata    asynchronous read port
//  Revision    : 1.0  initial release
// ============================================================================
module dmem32 #(
  parameter int WORD_AW = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic [WORD_AW-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(1<<WORD_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory / PC-update stage of the ARMv8 single-cycle datapath.
//                Holds the PC, resolves CBZ/B, performs 64-bit LDUR/STUR as
//                two 32-bit SRAM accesses while stalling the core, and drives
//                the write-back mux.
//  Ports       : clk, reset_n (async, active low)
//                instr_valid, ALUresult, writeData, ALUzero, PCbranch,
//                control_* decode bits                      (inputs)
//                PC, readData, writeBackData, stall, misaligned (outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
  import armv8_pkg::*;
#(
  parameter int          WORD_AW  = 8,
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [63:0] ALUresult,
  input  logic [63:0] writeData,
  input  logic        ALUzero,
  input  logic [63:0] PCbranch,
  input  logic        control_Branch,
  input  logic        control_UncondBranch,
  input  logic        control_MemRead,
  input  logic        control_MemWrite,
  input  logic        control_MemtoReg,
  output logic [63:0] PC,
  output logic [63:0] readData,
  output logic [63:0] writeBackData,
  output logic        stall,
  output logic        misaligned
);

  mem_state_t         r_state;
  logic [63:0]        r_pc;
  logic [63:0]        r_read_data;
  logic               r_misaligned;
  logic [WORD_AW-2:0] r_dw_addr;     // doubleword index; word LSB picks half
  logic [63:0]        r_wdata;
  logic               r_is_store;
  logic [31:0]        r_rd_lo;

  logic               w_mem_op;
  logic               w_stall;
  logic               w_take;
  logic [63:0]        w_pc_next;
  logic               w_mem_we;
  logic [WORD_AW-1:0] w_mem_addr;
  logic [31:0]        w_mem_wdata;
  logic [31:0]        w_mem_rdata;

  assign w_mem_op = instr_valid & (control_MemRead | control_MemWrite);

  // Stall is raised combinationally in IDLE so the PC never advances on the
  // edge that accepts a memory op. Held low while in reset.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:           w_stall = w_mem_op;
      ACC_LO, ACC_HI: w_stall = 1'b1;
      default:        w_stall = 1'b0;
    endcase
  end

  assign w_take    = control_UncondBranch | (control_Branch & ALUzero);
  assign w_pc_next = w_take ? PCbranch : (r_pc + PC_INCR);

  // Both halves use the latched doubleword index; the HI cycle selects the
  // odd word. A load-and-store op is a store, so the read result is dropped.
  assign w_mem_we    = r_is_store & ((r_state == ACC_LO) | (r_state == ACC_HI));
  assign w_mem_addr  = {r_dw_addr, (r_state == ACC_HI)};
  assign w_mem_wdata = (r_state == ACC_HI) ? r_wdata[63:32] : r_wdata[31:0];

  dmem32 #(
    .WORD_AW (WORD_AW)
  ) u_dmem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_mem_addr),
    .wdata (w_mem_wdata),
    .raddr (w_mem_addr),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_read_data  <= 64'h0;
      r_misaligned <= 1'b0;
      r_dw_addr    <= '0;
      r_wdata      <= 64'h0;
      r_is_store   <= 1'b0;
      r_rd_lo      <= 32'h0;
    end else begin
      r_misaligned <= 1'b0;
      if (!w_stall && instr_valid) r_pc <= w_pc_next;
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_dw_addr    <= ALUresult[WORD_AW+1:3];
            r_wdata      <= writeData;
            r_is_store   <= control_MemWrite;
            r_misaligned <= |ALUresult[2:0];
            r_state      <= ACC_LO;
          end
        end
        ACC_LO: begin
          if (!r_is_store) r_rd_lo <= w_mem_rdata;
          r_state <= ACC_HI;
        end
        ACC_HI: begin
          if (!r_is_store) r_read_data <= {w_mem_rdata, r_rd_lo};
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall         = reset_n & w_stall;
  assign PC            = r_pc;
  assign readData      = r_read_data;
  assign misaligned    = r_misaligned;
  assign writeBackData = control_MemtoReg ? r_read_data : ALUresult;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: table of single-cycle
//                PC/branch/write-back vectors plus hand sequences for
//                stores, loads, aliasing, misalignment and reset mid-access.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  localparam int WORD_AW = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [63:0] ALUresult;
  logic [63:0] writeData;
  logic        ALUzero;
  logic [63:0] PCbranch;
  logic        control_Branch;
  logic        control_UncondBranch;
  logic        control_MemRead;
  logic        control_MemWrite;
  logic        control_MemtoReg;
  logic [63:0] PC;
  logic [63:0] readData;
  logic [63:0] writeBackData;
  logic        stall;
  logic        misaligned;

  always #5 clk = ~clk;

  mem_stage #(
    .WORD_AW  (WORD_AW),
    .RESET_PC (64'h0)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_valid          (instr_valid),
    .ALUresult            (ALUresult),
    .writeData            (writeData),
    .ALUzero              (ALUzero),
    .PCbranch             (PCbranch),
    .control_Branch       (control_Branch),
    .control_UncondBranch (control_UncondBranch),
    .control_MemRead      (control_MemRead),
    .control_MemWrite     (control_MemWrite),
    .control_MemtoReg     (control_MemtoReg),
    .PC                   (PC),
    .readData             (readData),
    .writeBackData        (writeBackData),
    .stall                (stall),
    .misaligned           (misaligned)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid          = 1'b0;
    ALUresult            = 64'h0;
    writeData            = 64'h0;
    ALUzero              = 1'b0;
    PCbranch             = 64'h0;
    control_Branch       = 1'b0;
    control_UncondBranch = 1'b0;
    control_MemRead      = 1'b0;
    control_MemWrite     = 1'b0;
    control_MemtoReg     = 1'b0;
  endtask

  // Presents one memory op (entered #1 after an edge), follows it until the
  // PC has advanced, and checks stall length, misaligned pulse and new PC.
  task automatic mem_op(input string name, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] wdat,
                        input int exp_mis, input logic [63:0] exp_pc);
    int stall_cnt = 0;
    int mis_cnt   = 0;
    bit done      = 1'b0;
    instr_valid      = 1'b1;
    control_MemRead  = rd;
    control_MemWrite = wr;
    control_MemtoReg = rd & ~wr;
    ALUresult        = addr;
    writeData        = wdat;
    #1;
    for (int i = 0; i < 8 && !done; i++) begin
      if (misaligned) mis_cnt++;
      if (stall) stall_cnt++;
      else       done = 1'b1;
      step();
    end
    idle_inputs();
    check({name, " done"},       64'(done),      64'd1);
    check({name, " stall_cyc"},  64'(stall_cnt), 64'd3);
    check({name, " misaligned"}, 64'(mis_cnt),   64'(exp_mis));
    check({name, " pc"},         PC,             exp_pc);
  endtask

  typedef struct {
    logic        valid;
    logic        br;
    logic        ub;
    logic        z;
    logic [63:0] pcb;
    logic [63:0] alu;
    logic        m2r;
    logic [63:0] exp_pc;
    logic [63:0] exp_wb;
  } vec_t;

  vec_t vt [10];

  localparam logic [63:0] D1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] D2 = 64'h11112222_33334444;
  localparam logic [63:0] D3 = 64'hCAFEF00D_55AA55AA;
  localparam logic [63:0] D4 = 64'hAAAAAAAA_BBBBBBBB;
  localparam logic [63:0] D5 = 64'h99999999_77777777;

  initial begin
    //          valid br  ub  z   PCbranch                alu          m2r exp_pc                  exp_wb
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 64'h1234, 1'b0, 64'h4,                 64'h1234};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 64'h5678, 1'b0, 64'h8,                 64'h5678};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,                 64'h9ABC, 1'b0, 64'hC,                 64'h9ABC};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h40,                64'h1,    1'b0, 64'h40,                64'h1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h80,                64'h2,    1'b0, 64'h44,                64'h2};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h100,               64'h3,    1'b0, 64'h100,               64'h3};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h200,               64'h4,    1'b0, 64'h100,               64'h4};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 64'h5,    1'b0, 64'hFFFFFFFF_FFFFFFFC, 64'h5};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 64'h6,    1'b0, 64'h0,                 64'h6};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h300,               64'h7,    1'b1, 64'h4,                 64'h0};

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("reset pc",         PC,                  64'h0);
    check("reset stall",      64'(stall),          64'd0);
    check("reset readData",   readData,            64'h0);
    check("reset misaligned", 64'(misaligned),     64'd0);
    step();
    check("idle pc hold",     PC,                  64'h0);

    // Single-cycle vectors: PC sequencing, branches, hold, wrap, write-back.
    for (int i = 0; i < 10; i++) begin
      instr_valid          = vt[i].valid;
      control_Branch       = vt[i].br;
      control_UncondBranch = vt[i].ub;
      ALUzero              = vt[i].z;
      PCbranch             = vt[i].pcb;
      ALUresult            = vt[i].alu;
      control_MemtoReg     = vt[i].m2r;
      #1;
      check($sformatf("vec%0d wb", i),    writeBackData, vt[i].exp_wb);
      check($sformatf("vec%0d stall", i), 64'(stall),    64'd0);
      step();
      check($sformatf("vec%0d pc", i),    PC,            vt[i].exp_pc);
    end
    idle_inputs();

    // Reset asserted mid-cycle acts without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset pc",    PC,         64'h0);
    check("async reset stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    mem_op("stur 0x10", 1'b0, 1'b1, 64'h10, D1, 0, 64'h4);
    mem_op("ldur 0x10", 1'b1, 1'b0, 64'h10, 64'h0, 0, 64'h8);
    check("ldur 0x10 readData", readData, D1);
    control_MemtoReg = 1'b1;
    ALUresult        = 64'h5555;
    #1;
    check("ldur 0x10 wb", writeBackData, D1);
    step();
    idle_inputs();

    mem_op("ldur 0x13", 1'b1, 1'b0, 64'h13, 64'h0, 1, 64'hC);
    check("ldur 0x13 readData", readData, D1);

    mem_op("stur alias", 1'b0, 1'b1, 64'h408, D2, 0, 64'h10);
    mem_op("ldur 0x08",  1'b1, 1'b0, 64'h8, 64'h0, 0, 64'h14);
    check("alias readData", readData, D2);

    mem_op("rd+wr 0x18", 1'b1, 1'b1, 64'h18, D3, 0, 64'h18);
    check("rd+wr readData held", readData, D2);
    mem_op("ldur 0x18",  1'b1, 1'b0, 64'h18, 64'h0, 0, 64'h1C);
    check("ldur 0x18 readData", readData, D3);

    mem_op("stur 0x20 old", 1'b0, 1'b1, 64'h20, D4, 0, 64'h20);

    // Store aborted by reset in ACC_HI: low word already committed.
    instr_valid      = 1'b1;
    control_MemWrite = 1'b1;
    ALUresult        = 64'h20;
    writeData        = D5;
    step();  // ACC_LO
    step();  // ACC_HI
    #2;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("abort pc",       PC,         64'h0);
    check("abort stall",    64'(stall), 64'd0);
    check("abort readData", readData,   64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("abort idle stall", 64'(stall), 64'd0);
    mem_op("ldur 0x20", 1'b1, 1'b0, 64'h20, 64'h0, 0, 64'h4);
    check("ldur 0x20 readData", readData, 64'hAAAAAAAA_77777777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
